// File: rtl/bht_predictor_if.sv
// Lookup, update and statistics signals of the branch history table, bundled
// so the fetch/execute side (master) and the predictor (slave) share one port.
interface bht_predictor_if;
   logic [31:0] lk0_pc;
   logic        lk0_taken;
   logic [31:0] lk1_pc;
   logic        lk1_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic        upd_pred;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispred;

   modport master (
      output lk0_pc, lk1_pc, upd_valid, upd_pc, upd_taken, upd_pred,
      input  lk0_taken, lk1_taken, stat_branches, stat_mispred
   );

   modport slave (
      input  lk0_pc, lk1_pc, upd_valid, upd_pc, upd_taken, upd_pred,
      output lk0_taken, lk1_taken, stat_branches, stat_mispred
   );
endinterface

// File: rtl/bht_predictor.sv
// Dual-port 2-bit saturating-counter branch predictor with hit/mispredict statistics.
// Optional macro BHT_GSHARE_EN folds a global taken/not-taken history into the index.
module bht_predictor #(
   parameter int         ENTRIES  = 64,
   parameter logic [1:0] CNT_INIT = 2'b01,
   parameter int         HIST_LEN = 6
) (
   input logic           clk,
   input logic           rst,
   bht_predictor_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);

   logic [1:0]       cnt_q [ENTRIES];
   logic [IDX_W-1:0] hist_ext;
   logic [IDX_W-1:0] lk0_idx;
   logic [IDX_W-1:0] lk1_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [1:0]       upd_cnt;
   logic [1:0]       upd_next;
   logic [31:0]      branches_q;
   logic [31:0]      mispred_q;

`ifdef BHT_GSHARE_EN
   logic [HIST_LEN-1:0] hist_q;

   assign hist_ext = IDX_W'(hist_q);

   // Update indexing uses the history before this update's shift lands
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '0;
      end else if (bus.upd_valid) begin
         hist_q <= HIST_LEN'({hist_q, bus.upd_taken});
      end
   end
`else
   assign hist_ext = '0;
`endif

   assign lk0_idx = bus.lk0_pc[IDX_W+1:2] ^ hist_ext;
   assign lk1_idx = bus.lk1_pc[IDX_W+1:2] ^ hist_ext;
   assign upd_idx = bus.upd_pc[IDX_W+1:2] ^ hist_ext;

   assign bus.lk0_taken = cnt_q[lk0_idx][1];
   assign bus.lk1_taken = cnt_q[lk1_idx][1];
   assign upd_cnt       = cnt_q[upd_idx];

   always_comb begin
      upd_next = upd_cnt;
      if (bus.upd_taken) begin
         if (upd_cnt != 2'b11) upd_next = upd_cnt + 2'd1;
      end else begin
         if (upd_cnt != 2'b00) upd_next = upd_cnt - 2'd1;
      end
   end

   // Reset wins over a coincident update so no training survives it
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= CNT_INIT;
         end
      end else if (bus.upd_valid) begin
         cnt_q[upd_idx] <= upd_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         branches_q <= '0;
         mispred_q  <= '0;
      end else if (bus.upd_valid) begin
         if (branches_q != 32'hFFFF_FFFF) branches_q <= branches_q + 32'd1;
         if ((bus.upd_pred != bus.upd_taken) && (mispred_q != 32'hFFFF_FFFF)) begin
            mispred_q <= mispred_q + 32'd1;
         end
      end
   end

   assign bus.stat_branches = branches_q;
   assign bus.stat_mispred  = mispred_q;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.lk0_pc[31:IDX_W+2], bus.lk0_pc[1:0],
                             bus.lk1_pc[31:IDX_W+2], bus.lk1_pc[1:0],
                             bus.upd_pc[31:IDX_W+2], bus.upd_pc[1:0]};
endmodule

// File: tb/tb_bht_predictor.sv
// Directed scoreboard bench for bht_predictor: the driver queues expected
// lookups/statistics per cycle and a negedge monitor pops and compares them.
module tb_bht_predictor;
   logic clk;
   logic rst;

   bht_predictor_if bus ();

   bht_predictor #(
      .ENTRIES  (64),
      .CNT_INIT (2'b01),
      .HIST_LEN (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       name;
      logic        lk0;
      logic        lk1;
      logic [31:0] branches;
      logic [31:0] mispred;
   } exp_t;

   exp_t expQ[$];
   int   checks;
   int   errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: lookups are combinational, so sample mid-cycle before the edge
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         checkOutput({e.name, ".lk0_taken"}, 32'(bus.lk0_taken), 32'(e.lk0));
         checkOutput({e.name, ".lk1_taken"}, 32'(bus.lk1_taken), 32'(e.lk1));
         checkOutput({e.name, ".stat_branches"}, bus.stat_branches, e.branches);
         checkOutput({e.name, ".stat_mispred"}, bus.stat_mispred, e.mispred);
      end
   end

   task automatic applyStimulus(
      input string       name,
      input logic        r,
      input logic [31:0] pc0,
      input logic [31:0] pc1,
      input logic        uv,
      input logic [31:0] upc,
      input logic        ut,
      input logic        up,
      input logic        e0,
      input logic        e1,
      input logic [31:0] ebr,
      input logic [31:0] emis
   );
      exp_t e;
      rst           = r;
      bus.lk0_pc    = pc0;
      bus.lk1_pc    = pc1;
      bus.upd_valid = uv;
      bus.upd_pc    = upc;
      bus.upd_taken = ut;
      bus.upd_pred  = up;
      e.name     = name;
      e.lk0      = e0;
      e.lk1      = e1;
      e.branches = ebr;
      e.mispred  = emis;
      expQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic resetCycle(input logic uv);
      rst           = 1'b1;
      bus.lk0_pc    = 32'h0;
      bus.lk1_pc    = 32'h0;
      bus.upd_valid = uv;
      bus.upd_pc    = 32'h0;
      bus.upd_taken = 1'b1;
      bus.upd_pred  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int waitCycles;
      checks = 0;
      errors = 0;
      resetCycle(1'b1);
`ifdef BHT_GSHARE_EN
      applyStimulus("g_reset",  0, 32'h00, 32'h04, 0, 32'h0, 0, 0, 0, 0, 0, 0);
      applyStimulus("g_upd1",   0, 32'h00, 32'h0C, 1, 32'h0, 1, 0, 0, 0, 0, 0);
      applyStimulus("g_upd2",   0, 32'h0C, 32'h04, 1, 32'h0, 1, 0, 0, 1, 1, 1);
      applyStimulus("g_hist",   0, 32'h0C, 32'h00, 0, 32'h0, 0, 0, 1, 0, 2, 2);
      resetCycle(1'b1);
      applyStimulus("g_post",   0, 32'h0C, 32'h04, 0, 32'h0, 0, 0, 0, 0, 0, 0);
`else
      applyStimulus("reset_lookup",   0, 32'h00,  32'h04,  0, 32'h00, 0, 0, 0, 0, 0, 0);
      applyStimulus("train40_a",      0, 32'h40,  32'h40,  1, 32'h40, 1, 0, 0, 0, 0, 0);
      applyStimulus("train40_b",      0, 32'h40,  32'h40,  1, 32'h40, 1, 0, 1, 1, 1, 1);
      applyStimulus("train40_check",  0, 32'h40,  32'h00,  0, 32'h40, 0, 0, 1, 0, 2, 2);
      applyStimulus("dec1",           0, 32'h40,  32'h44,  1, 32'h40, 0, 1, 1, 0, 2, 2);
      applyStimulus("dec2",           0, 32'h40,  32'h44,  1, 32'h40, 0, 1, 1, 0, 3, 3);
      applyStimulus("dec3",           0, 32'h40,  32'h44,  1, 32'h40, 0, 0, 0, 0, 4, 4);
      applyStimulus("dec4_sat",       0, 32'h40,  32'h44,  1, 32'h40, 0, 0, 0, 0, 5, 4);
      applyStimulus("sat_low",        0, 32'h40,  32'h44,  0, 32'h40, 0, 0, 0, 0, 6, 4);
      applyStimulus("same_cycle",     0, 32'h80,  32'h80,  1, 32'h80, 1, 0, 0, 0, 6, 4);
      applyStimulus("same_cycle_nxt", 0, 32'h80,  32'h84,  0, 32'h80, 0, 0, 1, 0, 7, 5);
      applyStimulus("train0_a",       0, 32'h00,  32'h100, 1, 32'h00, 1, 1, 0, 0, 7, 5);
      applyStimulus("train0_b",       0, 32'h00,  32'h100, 1, 32'h00, 1, 1, 1, 1, 8, 5);
      applyStimulus("alias",          0, 32'h100, 32'h00,  0, 32'h00, 0, 0, 1, 1, 9, 5);
      applyStimulus("sat_high_upd",   0, 32'h100, 32'h00,  1, 32'h00, 1, 1, 1, 1, 9, 5);
      applyStimulus("dec_from_sat",   0, 32'h100, 32'h00,  1, 32'h00, 0, 1, 1, 1, 10, 5);
      applyStimulus("sat_high",       0, 32'h00,  32'h100, 0, 32'h00, 0, 0, 1, 1, 11, 6);
      applyStimulus("reset_with_upd", 1, 32'h00,  32'h40,  1, 32'h00, 1, 0, 1, 0, 11, 6);
      applyStimulus("post_reset",     0, 32'h00,  32'h80,  0, 32'h00, 0, 0, 0, 0, 0, 0);
`endif
      bus.upd_valid = 1'b0;
      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 10) begin
         @(posedge clk);
         waitCycles++;
      end
      if (expQ.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: actual %0d pending, required 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of 2-bit counters (power of 2, 4..1024); IDX_W = log2(ENTRIES).
REQ-002 SHALL have parameter CNT_INIT, default 2'b01, counter value after reset (weakly not-taken).
REQ-003 SHALL have parameter HIST_LEN, default 6, global history length (1..IDX_W); used only when BHT_GSHARE_EN is defined.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 lk0_pc  input  32  PC of first fetch-pair slot.
REQ-007 lk0_taken  output  1  prediction for lk0_pc, 1 = taken.
REQ-008 lk1_pc  input  32  PC of second fetch-pair slot.
REQ-009 lk1_taken  output  1  prediction for lk1_pc.
REQ-010 upd_valid  input  1  EX resolved a conditional branch this cycle.
REQ-011 upd_pc  input  32  PC of resolved branch.
REQ-012 upd_taken  input  1  actual outcome.
REQ-013 upd_pred  input  1  prediction originally used for that branch.
REQ-014 stat_branches  output  32  count of accepted updates.
REQ-015 stat_mispred  output  32  count of updates with upd_pred != upd_taken.

Function
REQ-016 Table SHALL hold ENTRIES 2-bit saturating counters; prediction = counter bit 1.
REQ-017 Base index SHALL be pc[IDX_W+1:2]; pc[1:0] ignored.
REQ-018 Lookups SHALL be combinational, zero latency, both ports independent, same cycle.
REQ-019 On upd_valid=1 at a clock edge, counter at upd index SHALL increment if upd_taken=1 (saturate at 3), decrement if 0 (saturate at 0).
REQ-020 Lookup and update to the same index in the same cycle SHALL return the pre-update value; new value visible the following cycle.
REQ-021 lk0 and lk1 hitting the same index SHALL return identical predictions.
REQ-022 upd_valid=0 SHALL leave all table, history and statistics state unchanged.
REQ-023 stat_branches SHALL increment by 1 per accepted update; stat_mispred by 1 when additionally upd_pred != upd_taken; both saturate at 32'hFFFF_FFFF (no wrap).
REQ-024 Statistics outputs SHALL be registered; they reflect updates through the previous edge.

Reset
REQ-025 rst=1 at an edge SHALL set every counter to CNT_INIT, history register to 0, both statistics to 0.
REQ-026 rst SHALL take priority over a coincident upd_valid; that update is discarded.
REQ-027 Reset completes in one cycle; lookups the cycle after rst deasserts SHALL return CNT_INIT[1] (0 by default).
REQ-028 Reset mid-operation SHALL discard all training; no partial state survives.

Configuration
REQ-029 Macro BHT_GSHARE_EN defined: HIST_LEN-bit global history register SHALL shift left inserting upd_taken on each accepted update; lookup and update index = base index XOR zero-extended history.
REQ-030 Update index under BHT_GSHARE_EN SHALL use the history value before that update's shift.
REQ-031 Macro BHT_GSHARE_EN undefined: no history register; index = base index only; port list identical in both builds.

Verification
REQ-032 rst 1 cycle, then lk0_pc=32'h0000_0000, lk1_pc=32'h0000_0004 -> lk0_taken=0, lk1_taken=0, stat_branches=0, stat_mispred=0.
REQ-033 Two updates upd_pc=32'h0000_0040, upd_taken=1, upd_pred=0 -> lk0_pc=32'h0000_0040 gives lk0_taken=1 after second edge (counter 01->10->11); stat_branches=2, stat_mispred=2.
REQ-034 Counter at 11, three updates upd_taken=0 -> prediction 1,0,0 after edges 1,2,3 (11->10->01->00); fourth not-taken update keeps 00.
REQ-035 Same cycle: lk0_pc=upd_pc=32'h0000_0080, counter 01, upd_taken=1 -> lk0_taken=0 that cycle, 1 next cycle.
REQ-036 ENTRIES=64: train 32'h0000_0000 to 11, look up 32'h0000_0100 (aliases index 0) -> taken=1; then rst with upd_valid=1 -> all predictions 0, stat_branches=0.
REQ-037 BHT_GSHARE_EN, HIST_LEN=6: updates taken,taken on pc 32'h0 -> history 6'b000011; lookup pc 32'h0000_000C (base 3) reads counter 0.
